tlb_assoc: RTL and testbench

//  Parametrised fully-associative TLB, successor to the fixed 8-entry TLB. Sits between fetch (port 0) and

---
 rtl/tlb_assoc_if.sv | 32 +++
 rtl/tlb_assoc.sv | 143 ++++++++++++++
 tb/tb_tlb_assoc.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_assoc_if.sv
// Lookup-side bus of the associative TLB: two translation ports (fetch and memory).
// The pipeline drives the master side; the TLB is the slave.
interface tlb_assoc_if #(
    parameter int unsigned PID_W = 12,
    parameter int unsigned VPN_W = 20,
    parameter int unsigned PPN_W = 6
) ();
    localparam int unsigned PA_W = PPN_W + 32 - VPN_W;

    logic             kmode;
    logic [PID_W-1:0] pid;
    logic [31:0]      addr0;
    logic [31:0]      addr1;
    logic             rd1;
    logic             wr1;
    logic             bubble1;
    logic [7:0]       exc_in;
    logic [7:0]       exc_out0;
    logic [7:0]       exc_out1;
    logic [PA_W-1:0]  addr0_out;
    logic [PA_W-1:0]  addr1_out;

    modport master (
        output kmode, pid, addr0, addr1, rd1, wr1, bubble1, exc_in,
        input  exc_out0, exc_out1, addr0_out, addr1_out
    );

    modport slave (
        input  kmode, pid, addr0, addr1, rd1, wr1, bubble1, exc_in,
        output exc_out0, exc_out1, addr0_out, addr1_out
    );
endinterface

// File: rtl/tlb_assoc.sv
// Fully-associative TLB with per-entry G/X/W/R permissions, write-over-hit,
// invalid-first then round-robin replacement and a multi-cycle invalidate-by-PID sweep.
module tlb_assoc #(
    parameter int unsigned ENTRIES       = 16,
    parameter int unsigned PID_W         = 12,
    parameter int unsigned VPN_W         = 20,
    parameter int unsigned PPN_W         = 6,
    parameter logic [31:0] KBYPASS_LIMIT = 32'h30000,
    parameter logic [7:0]  EXC_UMISS     = 8'h82,
    parameter logic [7:0]  EXC_KMISS     = 8'h83,
    parameter logic [7:0]  EXC_PROT      = 8'h84
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    tlb_assoc_if.slave             bus,
    input  logic [PID_W+VPN_W-1:0] probe_key,
    output logic                   probe_hit,
    output logic [PPN_W+3:0]       probe_data,
    input  logic                   we,
    input  logic [PPN_W+3:0]       write_data,
    input  logic                   inv_all,
    input  logic                   inv_pid_req,
    input  logic [PID_W-1:0]       inv_pid,
    output logic                   busy
);
    localparam int unsigned OFF_W  = 32 - VPN_W;
    localparam int unsigned PA_W   = PPN_W + OFF_W;
    localparam int unsigned KEY_W  = PID_W + VPN_W;
    localparam int unsigned DATA_W = PPN_W + 4;
    localparam int unsigned IDX_W  = $clog2(ENTRIES);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [ENTRIES-1:0] valid;
    logic [KEY_W-1:0]   key_q  [ENTRIES];
    logic [DATA_W-1:0]  data_q [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   idx;
    logic [PID_W-1:0]   sweep_pid;
    logic [0:0]         state;

    logic [KEY_W-1:0]   k0, k1;
    logic [ENTRIES-1:0] m0, m1, mp;

    function automatic logic entry_hit(input logic v, input logic [KEY_W-1:0] ek,
                                       input logic g, input logic [KEY_W-1:0] k);
        return v && (ek == k || (g && ek[VPN_W-1:0] == k[VPN_W-1:0]));
    endfunction

    assign k0 = {bus.pid, bus.addr0[31:OFF_W]};
    assign k1 = {bus.pid, bus.addr1[31:OFF_W]};

    for (genvar i = 0; i < ENTRIES; i++) begin : g_match
        assign m0[i] = entry_hit(valid[i], key_q[i], data_q[i][3], k0);
        assign m1[i] = entry_hit(valid[i], key_q[i], data_q[i][3], k1);
        assign mp[i] = entry_hit(valid[i], key_q[i], data_q[i][3], probe_key);
    end

    logic              hit0, hit1, hitp, inv_found;
    logic [DATA_W-1:0] d0, d1, dp;
    logic [IDX_W-1:0]  pidx, inv_idx, wr_idx;

    // Lowest-index match wins; data stays zero on a miss so the PPN reads as 0.
    always_comb begin
        hit0 = 1'b0; d0 = '0;
        hit1 = 1'b0; d1 = '0;
        hitp = 1'b0; dp = '0; pidx = '0;
        inv_found = 1'b0; inv_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (m0[i] && !hit0) begin hit0 = 1'b1; d0 = data_q[i]; end
            if (m1[i] && !hit1) begin hit1 = 1'b1; d1 = data_q[i]; end
            if (mp[i] && !hitp) begin hitp = 1'b1; dp = data_q[i]; pidx = IDX_W'(i); end
            if (!valid[i] && !inv_found) begin inv_found = 1'b1; inv_idx = IDX_W'(i); end
        end
    end

    assign probe_hit  = hitp;
    assign probe_data = dp;
    assign busy       = (state == S_SWEEP);
    assign wr_idx     = hitp ? pidx : (inv_found ? inv_idx : rr_ptr);

    logic       byp0, byp1;
    logic [7:0] miss_code, exc1;

    assign byp0      = bus.kmode && (bus.addr0 < KBYPASS_LIMIT);
    assign byp1      = bus.kmode && (bus.addr1 < KBYPASS_LIMIT);
    assign miss_code = bus.kmode ? EXC_KMISS : EXC_UMISS;

    always_comb begin
        if (byp0)       bus.exc_out0 = '0;
        else if (!hit0) bus.exc_out0 = miss_code;
        else if (!d0[2]) bus.exc_out0 = EXC_PROT;
        else            bus.exc_out0 = '0;
        bus.addr0_out = byp0 ? bus.addr0[PA_W-1:0] : {d0[DATA_W-1:4], bus.addr0[OFF_W-1:0]};
    end

    always_comb begin
        if (bus.exc_in != 8'h00)                          exc1 = bus.exc_in;
        else if (bus.bubble1 || byp1)                     exc1 = '0;
        else if (!hit1)                                   exc1 = miss_code;
        else if ((bus.rd1 && !d1[0]) || (bus.wr1 && !d1[1])) exc1 = EXC_PROT;
        else                                              exc1 = '0;
        bus.exc_out1 = exc1;
        if (exc1 != 8'h00)  bus.addr1_out = PA_W'({exc1, 2'b00});
        else if (byp1)      bus.addr1_out = bus.addr1[PA_W-1:0];
        else                bus.addr1_out = {d1[DATA_W-1:4], bus.addr1[OFF_W-1:0]};
    end

    // The write is placed after the sweep clear so it wins on the same index.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            rr_ptr    <= '0;
            idx       <= '0;
            sweep_pid <= '0;
            state     <= S_IDLE;
        end else if (clk_en) begin
            if (inv_all) begin
                valid <= '0;
                state <= S_IDLE;
            end else begin
                if (state == S_SWEEP) begin
                    if (valid[idx] && key_q[idx][KEY_W-1:VPN_W] == sweep_pid && !data_q[idx][3])
                        valid[idx] <= 1'b0;
                    if (idx == IDX_W'(ENTRIES - 1)) state <= S_IDLE;
                    else                           idx   <= idx + IDX_W'(1);
                end else if (inv_pid_req) begin
                    sweep_pid <= inv_pid;
                    idx       <= '0;
                    state     <= S_SWEEP;
                end
                if (we) begin
                    valid[wr_idx]  <= 1'b1;
                    key_q[wr_idx]  <= probe_key;
                    data_q[wr_idx] <= write_data;
                    if (!hitp && !inv_found) rr_ptr <= rr_ptr + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tlb_assoc.sv
// Self-checking bench for tlb_assoc: directed scenarios plus randomized traffic
// compared against a table-based reference model of the TLB.
module tb_tlb_assoc;
    logic        clk = 1'b0;
    logic        rst, clk_en;
    logic [31:0] probe_key;
    logic        probe_hit;
    logic [9:0]  probe_data;
    logic        we;
    logic [9:0]  write_data;
    logic        inv_all, inv_pid_req;
    logic [11:0] inv_pid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    tlb_assoc_if #(.PID_W(12), .VPN_W(20), .PPN_W(6)) bus ();

    tlb_assoc #(.ENTRIES(16), .PID_W(12), .VPN_W(20), .PPN_W(6)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus),
        .probe_key(probe_key), .probe_hit(probe_hit), .probe_data(probe_data),
        .we(we), .write_data(write_data), .inv_all(inv_all),
        .inv_pid_req(inv_pid_req), .inv_pid(inv_pid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: a table of entries plus replacement pointer and sweep progress.
    logic        m_v    [16];
    logic [31:0] m_key  [16];
    logic [9:0]  m_data [16];
    int          m_rr;
    bit          m_busy;
    int          m_idx;
    logic [11:0] m_spid;

    function automatic int m_find(input logic [31:0] k);
        for (int i = 0; i < 16; i++)
            if (m_v[i] && (m_key[i] == k || (m_data[i][3] && m_key[i][19:0] == k[19:0])))
                return i;
        return -1;
    endfunction

    task automatic tick();
        int hit, free;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
            m_rr = 0; m_busy = 0;
        end else if (clk_en) begin
            if (inv_all) begin
                for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
                m_busy = 0;
            end else begin
                hit  = m_find(probe_key);
                free = -1;
                for (int i = 15; i >= 0; i--) if (!m_v[i]) free = i;
                if (m_busy) begin
                    if (m_v[m_idx] && m_key[m_idx][31:20] == m_spid && !m_data[m_idx][3])
                        m_v[m_idx] = 1'b0;
                    if (m_idx == 15) m_busy = 0; else m_idx++;
                end else if (inv_pid_req) begin
                    m_spid = inv_pid; m_idx = 0; m_busy = 1;
                end
                if (we) begin
                    int tgt;
                    if (hit >= 0)       tgt = hit;
                    else if (free >= 0) tgt = free;
                    else begin tgt = m_rr; m_rr = (m_rr + 1) % 16; end
                    m_v[tgt] = 1'b1; m_key[tgt] = probe_key; m_data[tgt] = write_data;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_ports(output logic [7:0] e0, output logic [17:0] a0,
                               output logic [7:0] e1, output logic [17:0] a1);
        int  i0, i1;
        bit  b0, b1;
        logic [7:0] mc;
        mc = bus.kmode ? 8'h83 : 8'h82;
        b0 = bus.kmode && bus.addr0 < 32'h30000;
        b1 = bus.kmode && bus.addr1 < 32'h30000;
        i0 = m_find({bus.pid, bus.addr0[31:12]});
        i1 = m_find({bus.pid, bus.addr1[31:12]});
        if (b0)                  e0 = 8'h00;
        else if (i0 < 0)         e0 = mc;
        else if (!m_data[i0][2]) e0 = 8'h84;
        else                     e0 = 8'h00;
        a0 = b0 ? bus.addr0[17:0] : {(i0 < 0) ? 6'h00 : m_data[i0][9:4], bus.addr0[11:0]};
        if (bus.exc_in != 0)     e1 = bus.exc_in;
        else if (bus.bubble1 || b1) e1 = 8'h00;
        else if (i1 < 0)         e1 = mc;
        else if ((bus.rd1 && !m_data[i1][0]) || (bus.wr1 && !m_data[i1][1])) e1 = 8'h84;
        else                     e1 = 8'h00;
        if (e1 != 0)   a1 = {8'h00, e1, 2'b00};
        else if (b1)   a1 = bus.addr1[17:0];
        else           a1 = {(i1 < 0) ? 6'h00 : m_data[i1][9:4], bus.addr1[11:0]};
    endtask

    task automatic idle();
        clk_en = 1; we = 0; inv_all = 0; inv_pid_req = 0; inv_pid = '0;
        bus.rd1 = 0; bus.wr1 = 0; bus.bubble1 = 0; bus.exc_in = 8'h00;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic do_write(input logic [31:0] k, input logic [9:0] d);
        probe_key = k; write_data = d; we = 1; tick(); we = 0;
    endtask

    task automatic test_reset();
        bus.pid = 12'h000; bus.addr1 = 32'h0; probe_key = 32'h00300040;
        do_reset();
        bus.kmode = 0; bus.addr0 = 32'h00012345; #1;
        checks++; if (bus.exc_out0 !== 8'h82) begin errors++; $display("FAIL reset_umiss got %h exp 82", bus.exc_out0); end
        checks++; if (probe_hit !== 1'b0) begin errors++; $display("FAIL reset_probe_hit got %b exp 0", probe_hit); end
        checks++; if (probe_data !== 10'h0) begin errors++; $display("FAIL reset_probe_data got %h exp 0", probe_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        bus.kmode = 1; #1;
        checks++; if (bus.addr0_out !== 18'h12345) begin errors++; $display("FAIL bypass_addr got %h exp 12345", bus.addr0_out); end
        checks++; if (bus.exc_out0 !== 8'h00) begin errors++; $display("FAIL bypass_exc got %h exp 00", bus.exc_out0); end
    endtask

    task automatic test_translate();
        do_write({12'd1, 20'd5}, {6'h2A, 4'b0101});
        bus.kmode = 0; bus.pid = 12'd1; bus.addr0 = 32'h00005ABC; bus.addr1 = 32'h00005ABC;
        bus.wr1 = 1; #1;
        checks++; if (bus.addr0_out !== 18'h2AABC) begin errors++; $display("FAIL xlate_addr0 got %h exp 2aabc", bus.addr0_out); end
        checks++; if (bus.exc_out0 !== 8'h00) begin errors++; $display("FAIL xlate_exc0 got %h exp 00", bus.exc_out0); end
        checks++; if (bus.exc_out1 !== 8'h84) begin errors++; $display("FAIL store_prot got %h exp 84", bus.exc_out1); end
        checks++; if (bus.addr1_out !== 18'h210) begin errors++; $display("FAIL store_vec got %h exp 210", bus.addr1_out); end
        bus.wr1 = 0; bus.rd1 = 1; #1;
        checks++; if (bus.exc_out1 !== 8'h00 || bus.addr1_out !== 18'h2AABC) begin
            errors++; $display("FAIL load_ok got %h/%h exp 00/2aabc", bus.exc_out1, bus.addr1_out); end
        idle();
    endtask

    task automatic test_fill();
        logic [9:0] d;
        do_reset();
        for (int i = 0; i < 16; i++) do_write({12'h7, 20'h100 + 20'(i)}, 10'($urandom) & 10'h3F7);
        do_write({12'h7, 20'h200}, 10'h155);
        probe_key = {12'h7, 20'h100}; #1;
        checks++; if (probe_hit !== 1'b0) begin errors++; $display("FAIL evict_slot0 got %b exp 0", probe_hit); end
        probe_key = {12'h7, 20'h200}; #1;
        checks++; if (probe_hit !== 1'b1 || probe_data !== 10'h155) begin
            errors++; $display("FAIL new17 got %b/%h exp 1/155", probe_hit, probe_data); end
        do_write({12'h7, 20'h201}, 10'h0F3);
        probe_key = {12'h7, 20'h101}; #1;
        checks++; if (probe_hit !== 1'b0) begin errors++; $display("FAIL evict_slot1 got %b exp 0", probe_hit); end
        d = 10'h2C7;
        do_write({12'h7, 20'h105}, d);
        probe_key = {12'h7, 20'h105}; #1;
        checks++; if (probe_data !== d) begin errors++; $display("FAIL rewrite_data got %h exp %h", probe_data, d); end
        probe_key = {12'h7, 20'h102}; #1;
        checks++; if (probe_hit !== 1'b1) begin errors++; $display("FAIL rewrite_keeps got %b exp 1", probe_hit); end
        for (int i = 0; i < 16; i++) begin
            int mi;
            probe_key = {12'h7, 20'h100 + 20'(i)}; #1;
            mi = m_find(probe_key);
            checks++; if (probe_hit !== (mi >= 0) || (mi >= 0 && probe_data !== m_data[mi])) begin
                errors++; $display("FAIL fill_probe[%0d] got %b/%h", i, probe_hit, probe_data); end
        end
    endtask

    task automatic load_sweep_set();
        for (int i = 0; i < 4; i++) do_write({12'd3, 20'h40 + 20'(i)}, 10'h0A7);
        do_write({12'd3, 20'h50}, 10'h0AF);
        do_write({12'd4, 20'h60}, 10'h0A7);
        do_write({12'd4, 20'h61}, 10'h0A7);
    endtask

    task automatic test_sweep();
        int n;
        logic [31:0] keys [7];
        bit exp_hit;
        do_reset();
        load_sweep_set();
        inv_pid = 12'd3; inv_pid_req = 1; tick(); inv_pid_req = 0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 3) begin inv_pid_req = 1; inv_pid = 12'd4; end
            else inv_pid_req = 0;
            n++; tick();
        end
        inv_pid_req = 0;
        checks++; if (n != 16) begin errors++; $display("FAIL sweep_busy_cycles got %0d exp 16", n); end
        keys = '{{12'd3,20'h40}, {12'd3,20'h41}, {12'd3,20'h42}, {12'd3,20'h43},
                 {12'd3,20'h50}, {12'd4,20'h60}, {12'd4,20'h61}};
        for (int i = 0; i < 7; i++) begin
            probe_key = keys[i]; #1;
            exp_hit = (i >= 4);
            checks++; if (probe_hit !== exp_hit || exp_hit != (m_find(keys[i]) >= 0)) begin
                errors++; $display("FAIL sweep_probe[%0d] got %b exp %b", i, probe_hit, exp_hit); end
        end
    endtask

    task automatic test_sweep_collision();
        int n;
        for (int i = 0; i < 4; i++) do_write({12'd3, 20'h40 + 20'(i)}, 10'h0A7);
        inv_pid = 12'd3; inv_pid_req = 1; tick(); inv_pid_req = 0;
        tick(); tick();
        do_write({12'd3, 20'h42}, 10'h1F7);
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; tick(); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collide_done got busy %b exp 0", busy); end
        for (int i = 0; i < 4; i++) begin
            probe_key = {12'd3, 20'h40 + 20'(i)}; #1;
            checks++; if (probe_hit !== (i == 2) || (m_find(probe_key) >= 0) != (i == 2)) begin
                errors++; $display("FAIL collide_probe[%0d] got %b exp %b", i, probe_hit, i == 2); end
        end
    endtask

    task automatic test_exc();
        bus.kmode = 0; bus.pid = 12'h9; bus.addr1 = 32'h00777123;
        bus.exc_in = 8'h81; bus.bubble1 = 1; #1;
        checks++; if (bus.exc_out1 !== 8'h81 || bus.addr1_out !== 18'h204) begin
            errors++; $display("FAIL exc_in_prio got %h/%h exp 81/204", bus.exc_out1, bus.addr1_out); end
        bus.exc_in = 8'h00; #1;
        checks++; if (bus.exc_out1 !== 8'h00 || bus.addr1_out !== 18'h00123) begin
            errors++; $display("FAIL bubble_miss got %h/%h exp 00/00123", bus.exc_out1, bus.addr1_out); end
        bus.bubble1 = 0; bus.kmode = 1; bus.addr1 = 32'h0002FFFF; #1;
        checks++; if (bus.exc_out1 !== 8'h00 || bus.addr1_out !== 18'h2FFFF) begin
            errors++; $display("FAIL bypass_edge got %h/%h exp 00/2ffff", bus.exc_out1, bus.addr1_out); end
        bus.addr1 = 32'h00030000; #1;
        checks++; if (bus.exc_out1 !== 8'h83 || bus.addr1_out !== 18'h20C) begin
            errors++; $display("FAIL kmiss_limit got %h/%h exp 83/20c", bus.exc_out1, bus.addr1_out); end
        idle();
    endtask

    task automatic test_random();
        logic [7:0]  e0, e1;
        logic [17:0] a0, a1;
        int mi;
        for (int it = 0; it < 400; it++) begin
            bus.kmode   = ($urandom_range(0, 3) == 0);
            bus.pid     = 12'($urandom_range(1, 3));
            bus.addr0   = {12'h0, 8'($urandom_range(8'h28, 8'h37)), 12'($urandom)};
            bus.addr1   = {12'h0, 8'($urandom_range(8'h28, 8'h37)), 12'($urandom)};
            bus.rd1     = $urandom_range(0, 1);
            bus.wr1     = $urandom_range(0, 1);
            bus.bubble1 = ($urandom_range(0, 7) == 0);
            bus.exc_in  = ($urandom_range(0, 9) == 0) ? 8'h81 : 8'h00;
            probe_key   = {12'($urandom_range(1, 3)), 20'($urandom_range(8'h28, 8'h37))};
            write_data  = 10'($urandom);
            we          = ($urandom_range(0, 2) == 0);
            inv_pid_req = ($urandom_range(0, 29) == 0);
            inv_pid     = 12'($urandom_range(1, 3));
            inv_all     = ($urandom_range(0, 79) == 0);
            clk_en      = ($urandom_range(0, 9) != 0);
            #1;
            model_ports(e0, a0, e1, a1);
            mi = m_find(probe_key);
            checks++; if (bus.exc_out0 !== e0 || bus.addr0_out !== a0) begin
                errors++; $display("FAIL rnd_port0 it=%0d got %h/%h exp %h/%h", it, bus.exc_out0, bus.addr0_out, e0, a0); end
            checks++; if (bus.exc_out1 !== e1 || bus.addr1_out !== a1) begin
                errors++; $display("FAIL rnd_port1 it=%0d got %h/%h exp %h/%h", it, bus.exc_out1, bus.addr1_out, e1, a1); end
            checks++; if (probe_hit !== (mi >= 0) || probe_data !== ((mi >= 0) ? m_data[mi] : 10'h0)) begin
                errors++; $display("FAIL rnd_probe it=%0d got %b/%h", it, probe_hit, probe_data); end
            checks++; if (busy !== m_busy) begin
                errors++; $display("FAIL rnd_busy it=%0d got %b exp %b", it, busy, m_busy); end
            tick();
        end
        idle();
    endtask

    task automatic test_inv_all();
        do_reset();
        load_sweep_set();
        inv_pid = 12'd3; inv_pid_req = 1; tick(); inv_pid_req = 0;
        repeat (4) tick();
        inv_all = 1; probe_key = {12'd5, 20'h77}; write_data = 10'h0FF; we = 1;
        tick();
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inv_all_busy got %b exp 0", busy); end
        #1;
        checks++; if (probe_hit !== 1'b0) begin errors++; $display("FAIL inv_all_drop got %b exp 0", probe_hit); end
        probe_key = {12'd4, 20'h60}; #1;
        checks++; if (probe_hit !== 1'b0) begin errors++; $display("FAIL inv_all_clear got %b exp 0", probe_hit); end
        do_write({12'd2, 20'h33}, 10'h0C7);
        clk_en = 0; we = 1; inv_all = 1; inv_pid_req = 1; inv_pid = 12'd2;
        probe_key = {12'd2, 20'h34}; write_data = 10'h3FF;
        tick();
        idle();
        #1;
        checks++; if (probe_hit !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL clken_hold got %b/%b exp 0/0", probe_hit, busy); end
        probe_key = {12'd2, 20'h33}; #1;
        checks++; if (probe_hit !== 1'b1 || probe_data !== 10'h0C7) begin
            errors++; $display("FAIL clken_keep got %b/%h exp 1/0c7", probe_hit, probe_data); end
    endtask

    initial begin
        rst = 1; bus.kmode = 0; bus.pid = '0; bus.addr0 = '0; bus.addr1 = '0;
        probe_key = '0; write_data = '0;
        idle();
        test_reset();
        test_translate();
        test_fill();
        test_sweep();
        test_sweep_collision();
        test_exc();
        test_random();
        test_inv_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
